// File: rtl/isqrt_rr_arbiter.sv
// rtl/isqrt_rr_arbiter.sv - round-robin sharing of one isqrt instance between N_REQ requesters
module isqrt_rr_arbiter #(
  parameter int N_REQ   = 3,
  parameter int MAX_OUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_vld,
  input  logic [N_REQ*32-1:0] req_x,
  output logic [N_REQ-1:0]   req_rdy,
  output logic [N_REQ-1:0]   rsp_vld,
  output logic [15:0]        rsp_y,
  output logic               isqrt_x_vld,
  output logic [31:0]        isqrt_x,
  input  logic               isqrt_y_vld,
  input  logic [15:0]        isqrt_y,
  output logic               err
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_found;
  logic             grant;
  logic [ID_W:0]    cand;
  logic [ID_W-1:0]  fifo_mem [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             push;
  logic             pop;
  logic             empty_pop;

  // A pop frees its slot only from the next cycle, so full blocks issue even during a pop.
  // No transfer is accepted while in reset because isqrt is held in reset too.
  assign full        = (count == CNT_W'(MAX_OUT));
  assign grant       = gnt_found && !full && !rst;
  assign push        = grant;
  assign pop         = isqrt_y_vld && (count != '0);
  assign empty_pop   = isqrt_y_vld && (count == '0);
  assign isqrt_x_vld = grant;

  // Round-robin search: first asserted req_vld at or after ptr, wrapping at N_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!gnt_found && req_vld[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  // One-hot accept and zero-cycle argument mux toward isqrt.
  always_comb begin
    req_rdy = '0;
    isqrt_x = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        req_rdy[i] = grant;
        isqrt_x    = req_x[32*i +: 32];
      end
    end
  end

  // Tag storage: records which requester owns each in-flight operation.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= gnt_idx;
  end

  // Round-robin pointer, FIFO pointers/occupancy, result routing and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rsp_vld <= '0;
      rsp_y   <= '0;
      err     <= 1'b0;
    end else begin
      if (push) begin
        ptr    <= (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
        wr_ptr <= (wr_ptr == PTR_W'(MAX_OUT-1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(MAX_OUT-1)) ? '0 : rd_ptr + PTR_W'(1);
        rsp_y  <= isqrt_y;
      end
      for (int i = 0; i < N_REQ; i++) begin
        rsp_vld[i] <= pop && (fifo_mem[rd_ptr] == ID_W'(i));
      end
      if (empty_pop) err <= 1'b1;
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// tb/tb_isqrt_rr_arbiter.sv - self-checking bench for isqrt_rr_arbiter
module tb_isqrt_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_vld;
  logic [95:0] req_x;
  logic [2:0]  req_rdy;
  logic [2:0]  rsp_vld;
  logic [15:0] rsp_y;
  logic        isqrt_x_vld;
  logic [31:0] isqrt_x;
  logic        isqrt_y_vld;
  logic [15:0] isqrt_y;
  logic        err;

  int n_chk  = 0;
  int n_fail = 0;

  isqrt_rr_arbiter #(.N_REQ(3), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_y(rsp_y), .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
    logic [63:0] r;
    logic [63:0] t;
    r = 64'd0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, x}) r = t;
    end
    return r[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // fixed-latency isqrt model sharing rst
  int   lat = 1;
  logic inj_vld = 1'b0;
  bit        pipe_v [16];
  bit [31:0] pipe_x [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= isqrt_x_vld;
      pipe_x[0] <= isqrt_x;
      for (int i = 1; i < 16; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_x[i] <= pipe_x[i-1];
      end
    end
  end
  always_comb begin
    isqrt_y_vld = pipe_v[lat-1] | inj_vld;
    isqrt_y     = isqrt_ref(pipe_x[lat-1]);
  end

  // scoreboard: expected routing pushed on accept, popped on rsp_vld
  typedef struct { int id; logic [15:0] y; } exp_t;
  exp_t sb[$];
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (|rsp_vld) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", {29'd0, rsp_vld}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_vld", {29'd0, rsp_vld}, 32'd1 << e.id);
          chk("rsp_y", {16'd0, rsp_y}, {16'd0, e.y});
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          e.id = i;
          e.y  = isqrt_ref(req_x[32*i +: 32]);
          sb.push_back(e);
        end
      end
    end
  end

  typedef struct {
    logic [2:0]  vld;
    logic [31:0] x0, x1, x2;
    logic [2:0]  rdy;
    logic [31:0] xexp;
    logic [1:0]  ptr;
  } vec_t;
  vec_t tbl [10];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_vld = 3'b000;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string nm, input int max_cyc);
    req_vld = 3'b000;
    for (int i = 0; i < max_cyc && sb.size() != 0; i++) cyc();
    cyc();
    chk(nm, sb.size(), 0);
  endtask

  initial begin
    logic [2:0] rem;
    logic [2:0] prev;
    int g0, g2, viol, maxcnt;
    logic [2:0] seen;
    logic [2:0] bp_exp [10];

    tbl[0] = '{3'b010, 32'd5,          32'd16,  32'd7,       3'b010, 32'd16,          2'd2};
    tbl[1] = '{3'b111, 32'd1,          32'd2,   32'd81,      3'b100, 32'd81,          2'd0};
    tbl[2] = '{3'b111, 32'd64,         32'd3,   32'd4,       3'b001, 32'd64,          2'd1};
    tbl[3] = '{3'b101, 32'd9,          32'd0,   32'd144,     3'b100, 32'd144,         2'd0};
    tbl[4] = '{3'b000, 32'd1,          32'd1,   32'd1,       3'b000, 32'd0,           2'd0};
    tbl[5] = '{3'b110, 32'd0,          32'd225, 32'd0,       3'b010, 32'd225,         2'd2};
    tbl[6] = '{3'b011, 32'hFFFF_FFFF,  32'd0,   32'd0,       3'b001, 32'hFFFF_FFFF,   2'd1};
    tbl[7] = '{3'b001, 32'd2,          32'd0,   32'd0,       3'b001, 32'd2,           2'd1};
    tbl[8] = '{3'b100, 32'd0,          32'd0,   32'd1000000, 3'b100, 32'd1000000,     2'd0};
    tbl[9] = '{3'b111, 32'd3,          32'd8,   32'd15,      3'b001, 32'd3,           2'd1};
    bp_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};

    rst = 1'b1; req_vld = 3'b000; req_x = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_rsp_vld", {29'd0, rsp_vld}, 32'd0);
    chk("reset_rsp_y", {16'd0, rsp_y}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_count", 32'(dut.count), 32'd0);
    chk("reset_ptr", 32'(dut.ptr), 32'd0);
    chk("reset_x_vld", {31'd0, isqrt_x_vld}, 32'd0);
    cyc();

    // table-driven grant vectors, isqrt latency 1
    lat = 1;
    for (int r = 0; r < 10; r++) begin
      req_vld = tbl[r].vld;
      req_x   = {tbl[r].x2, tbl[r].x1, tbl[r].x0};
      #1;
      chk($sformatf("tbl%0d_rdy", r), {29'd0, req_rdy}, {29'd0, tbl[r].rdy});
      chk($sformatf("tbl%0d_x_vld", r), {31'd0, isqrt_x_vld}, {31'd0, |tbl[r].rdy});
      if (tbl[r].rdy != 3'b000) chk($sformatf("tbl%0d_x", r), isqrt_x, tbl[r].xexp);
      cyc();
      chk($sformatf("tbl%0d_ptr", r), 32'(dut.ptr), {30'd0, tbl[r].ptr});
    end
    drain("tbl_drain", 20);

    // contention from reset
    do_reset();
    req_x = {32'd25, 32'd49, 32'd100};
    rem = 3'b111;
    for (int c = 0; c < 3; c++) begin
      req_vld = rem;
      #1;
      chk($sformatf("cont%0d_rdy", c), {29'd0, req_rdy}, 32'd1 << c);
      cyc();
      rem = rem & ~(3'b001 << c);
    end
    drain("cont_drain", 20);

    // fairness between req0 and req2
    g0 = 0; g2 = 0; viol = 0; prev = 3'b000;
    for (int c = 0; c < 10; c++) begin
      req_x = {$urandom, $urandom, $urandom};
      req_vld = 3'b101;
      #1;
      if (req_rdy == 3'b001) g0++;
      if (req_rdy == 3'b100) g2++;
      if (req_rdy == prev) viol++;
      prev = req_rdy;
      cyc();
    end
    chk("fair_g0", g0, 5);
    chk("fair_g2", g2, 5);
    chk("fair_consec", viol, 0);
    drain("fair_drain", 20);

    // backpressure with isqrt latency 8
    do_reset();
    lat = 8;
    maxcnt = 0;
    for (int c = 0; c < 30; c++) begin
      req_x = {32'd0, 32'd0, 32'(1000 + c * 17)};
      req_vld = 3'b001;
      #1;
      if (c < 10) chk($sformatf("bp%0d_rdy", c), {29'd0, req_rdy}, {29'd0, bp_exp[c]});
      if (int'(dut.count) > maxcnt) maxcnt = int'(dut.count);
      cyc();
    end
    chk("bp_max_count", maxcnt, 4);
    drain("bp_drain", 60);

    // steady state, simultaneous push/pop with latency 2
    do_reset();
    lat = 2;
    for (int c = 0; c < 12; c++) begin
      req_x = {$urandom, $urandom, $urandom};
      req_vld = 3'b111;
      #1;
      chk($sformatf("ss%0d_rdy", c), {29'd0, req_rdy}, 32'd1 << (c % 3));
      if (c >= 2) chk($sformatf("ss%0d_count", c), 32'(dut.count), 32'd2);
      cyc();
    end
    drain("ss_drain", 20);

    // empty pop error, then reset with operations in flight
    do_reset();
    lat = 8;
    #1;
    chk("err_before", {31'd0, err}, 32'd0);
    inj_vld = 1'b1;
    cyc();
    inj_vld = 1'b0;
    chk("err_set", {31'd0, err}, 32'd1);
    chk("err_rsp_vld", {29'd0, rsp_vld}, 32'd0);
    chk("err_count", 32'(dut.count), 32'd0);
    repeat (3) cyc();
    chk("err_sticky", {31'd0, err}, 32'd1);
    req_x = {32'd0, 32'd36, 32'd49};
    req_vld = 3'b011;
    repeat (2) cyc();
    req_vld = 3'b000;
    chk("inflight_count", 32'(dut.count), 32'd2);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_count", 32'(dut.count), 32'd0);
    chk("rst_ptr", 32'(dut.ptr), 32'd0);
    seen = 3'b000;
    for (int c = 0; c < 15; c++) begin
      seen = seen | rsp_vld;
      cyc();
    end
    chk("rst_no_rsp", {29'd0, seen}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
